axi_apb_bridge: RTL and testbench
=================================

Name: axi_apb_bridge

Overview:
- AXI4 slave to APB master bridge, single clock domain.
- Accepts AXI4 read and write bursts, then issues one APB transfer per beat to a downstream APB completer such as apb_stub.
- One transaction in flight at a time; round-robin arbitration between the read and write channels.
- Sits between an AXI interconnect and the APB peripheral segment.

Parameters:
IWIDTH, 4, ID width (bits)
AWIDTH, 10, address width (bits), identical on the AXI and APB sides
DSIZE, 2, data size (2^DSIZE bytes), identical on both sides
DBYTES, 1<<DSIZE, hidden: data bytes
DWIDTH, DBYTES*8, hidden: data width (bits)

Ports:
pclk  in  1  clock, shared by the AXI and APB sides
aresetn  in  1  reset, asynchronous, active-low
awid/awaddr/awlen/awsize/awburst/awprot/awvalid  in  IWIDTH/AWIDTH/8/3/2/3/1  AXI write address channel
awlock/awcache  in  1/4  accepted and ignored
awready  out  1  write address ready
wdata/wstrb/wlast/wvalid  in  DWIDTH/DBYTES/1/1  AXI write data channel; wlast is ignored, beat count governs
wready  out  1  write data ready
bid/bresp/bvalid  out  IWIDTH/2/1  write response channel
bready  in  1  write response ready
arid/araddr/arlen/arsize/arburst/arprot/arvalid  in  IWIDTH/AWIDTH/8/3/2/3/1  AXI read address channel
arlock/arcache  in  1/4  accepted and ignored
arready  out  1  read address ready
rid/rdata/rresp/rlast/rvalid  out  IWIDTH/DWIDTH/2/1/1  read data channel
rready  in  1  read data ready
psel/penable/pwrite  out  1/1/1  APB control
pprot  out  3  copied from awprot or arprot
paddr  out  AWIDTH  APB address
pstrb  out  DBYTES  APB write strobe
pwdata  out  DWIDTH  APB write data
prdata/pready/pslverr  in  DWIDTH/1/1  APB completer response

Behaviour:
- FSM states: IDLE, WDATA, SETUP, ACCESS, BRESP, RDATA.
- Reset (asynchronous):
  - State IDLE, prio=write.
  - psel, penable, pwrite, bvalid, rvalid, wready are 0.
  - paddr, pstrb, pwdata, pprot are 0.
  - awready and arready are gated to 0 while aresetn is low.
  - Reset asserted mid-burst abandons the transaction immediately; no response is issued.
- IDLE, ready signals (combinational, may depend on valid):
  - awready = awvalid & (!arvalid | prio==write).
  - arready = arvalid & (!awvalid | prio==read).
- IDLE, on an accepted handshake:
  - Latch id, addr, len, size, burst, prot.
  - Clear beat counter and the error flag.
  - prio toggles to the other channel.
  - Write goes to WDATA; read goes to SETUP.
- WDATA:
  - wready=1.
  - On wvalid: capture wdata→pwdata and wstrb→pstrb, then go to SETUP.
  - wready drops the cycle after the capture (one beat per APB transfer).
- SETUP: psel=1, penable=0, paddr=current address. Next state is ACCESS.
- ACCESS: psel=1, penable=1. Hold until pready.
- On pready in ACCESS:
  - Write: OR pslverr into the error flag. Last beat (count==len) goes to BRESP; otherwise advance the address and go to WDATA.
  - Read: register rdata=prdata and rresp=pslverr?2'b10:2'b00, set rvalid=1, go to RDATA.
- A back-to-back APB transfer therefore always passes through a fresh SETUP phase.
- RDATA:
  - rlast = (count==len).
  - Hold rdata, rresp, rlast and rvalid until rready.
  - On rready: if last, go to IDLE; else advance the address, increment count, go to SETUP.
- BRESP:
  - bvalid=1, bid=latched id, bresp = error flag ? 2'b10 (SLVERR) : 2'b00.
  - Hold until bready, then go to IDLE.
- APB write data:
  - pwrite=1 for write transactions, 0 for reads.
  - pstrb=0 during reads.
  - psel is deasserted in IDLE/WDATA/BRESP/RDATA.
- Address advance, with step = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr+step, truncated to AWIDTH (natural wrap at 2^AWIDTH).
  - WRAP (10): boundary = (len+1)*step. Low bits wrap within the boundary-aligned window; high bits are held.
  - Reserved (11): treated as INCR.
- Size and burst limits:
  - size > DSIZE: not checked; the behaviour is the step rule above.
  - len up to 255 (256 beats) is supported; the beat counter is 8 bits.

Test Plan:
- Single write: awaddr=0x10, awlen=0, wdata=0xA5A5A5A5, wstrb=0xF → one APB transfer (SETUP then ACCESS) with paddr=0x10, pwdata=0xA5A5A5A5, pstrb=0xF; then bresp=00, bid=awid.
- INCR read burst: araddr=0x20, arlen=3, arsize=2, with pready delayed 2 cycles per beat → paddr 0x20, 0x24, 0x28, 0x2C; 4 rvalid beats, rlast only on the 4th, rid=arid.
- WRAP write: awaddr=0x38, awlen=3, awsize=2 → paddr 0x38, 0x3C, 0x30, 0x34. With pslverr=1 on beat 2 only → bresp=10.
- Backpressure and error: hold rready=0 for 5 cycles → rvalid/rdata stable and no new psel. With pslverr=1 on a read beat → rresp=10 for that beat only.
- Arbitration: awvalid and arvalid both high right after reset → write granted first, then the read. With both high again → the write is granted (prio alternates).
- Reset: assert aresetn low during ACCESS of beat 2 of 4 → psel, penable, rvalid, bvalid drop asynchronously; after release, a fresh write completes normally.

Source files
------------

// File: rtl/axi_apb_bridge.sv
// AXI4 slave to APB master bridge: one AXI burst in flight, one APB transfer per beat,
// round-robin arbitration between the write and read address channels.
module axi_apb_bridge #(
  parameter int  IWIDTH = 4,
  parameter int  AWIDTH = 10,
  parameter int  DSIZE  = 2,
  localparam int DBYTES = 1 << DSIZE,
  localparam int DWIDTH = DBYTES * 8
) (
  input  logic              pclk,
  input  logic              aresetn,
  input  logic [IWIDTH-1:0] awid,
  input  logic [AWIDTH-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  input  logic              awlock,
  input  logic [3:0]        awcache,
  output logic              awready,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [DBYTES-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [IWIDTH-1:0] bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [IWIDTH-1:0] arid,
  input  logic [AWIDTH-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  input  logic              arlock,
  input  logic [3:0]        arcache,
  output logic              arready,
  output logic [IWIDTH-1:0] rid,
  output logic [DWIDTH-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [2:0]        pprot,
  output logic [AWIDTH-1:0] paddr,
  output logic [DBYTES-1:0] pstrb,
  output logic [DWIDTH-1:0] pwdata,
  input  logic [DWIDTH-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, BRESP, RDATA} state_t;

  state_t              state;
  logic                prio;  // 0: write channel has priority, 1: read channel
  logic [IWIDTH-1:0]   id_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [AWIDTH-1:0]   addr_nxt;
  logic [7:0]          len_q;
  logic [7:0]          cnt_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic                unused_ok;

  // WRAP keeps the bits above the (len+1)*step window and wraps the bits inside it.
  function automatic logic [AWIDTH-1:0] next_addr(input logic [AWIDTH-1:0] a,
                                                  input logic [2:0] sz,
                                                  input logic [1:0] bt,
                                                  input logic [7:0] ln);
    logic [AWIDTH-1:0] step;
    logic [AWIDTH-1:0] mask;
    logic [15:0]       bound;
    step  = AWIDTH'(1) << sz;
    bound = (16'(ln) + 16'd1) << sz;
    mask  = AWIDTH'(bound - 16'd1);
    case (bt)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
      default: next_addr = a + step;
    endcase
  endfunction

  assign addr_nxt  = next_addr(addr_q, size_q, burst_q, len_q);
  assign awready   = aresetn && (state == IDLE) && awvalid && (!arvalid || !prio);
  assign arready   = aresetn && (state == IDLE) && arvalid && (!awvalid || prio);
  assign bid       = id_q;
  assign rid       = id_q;
  assign bresp     = err_q ? 2'b10 : 2'b00;
  assign unused_ok = ^{awlock, awcache, arlock, arcache, wlast};

  always_ff @(posedge pclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      prio    <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      wready  <= 1'b0;
      paddr   <= '0;
      pstrb   <= '0;
      pwdata  <= '0;
      pprot   <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (awready) begin
            id_q    <= awid;
            addr_q  <= awaddr;
            len_q   <= awlen;
            size_q  <= awsize;
            burst_q <= awburst;
            pprot   <= awprot;
            pwrite  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            prio    <= 1'b1;
            wready  <= 1'b1;
            state   <= WDATA;
          end else if (arready) begin
            id_q    <= arid;
            addr_q  <= araddr;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            pprot   <= arprot;
            pwrite  <= 1'b0;
            pstrb   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            prio    <= 1'b0;
            psel    <= 1'b1;
            paddr   <= araddr;
            state   <= SETUP;
          end
        end
        WDATA: begin
          if (wvalid) begin
            pwdata <= wdata;
            pstrb  <= wstrb;
            wready <= 1'b0;
            psel   <= 1'b1;
            paddr  <= addr_q;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (pwrite) begin
              err_q <= err_q | pslverr;
              if (cnt_q == len_q) begin
                bvalid <= 1'b1;
                state  <= BRESP;
              end else begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
                wready <= 1'b1;
                state  <= WDATA;
              end
            end else begin
              rdata  <= prdata;
              rresp  <= pslverr ? 2'b10 : 2'b00;
              rlast  <= (cnt_q == len_q);
              rvalid <= 1'b1;
              state  <= RDATA;
            end
          end
        end
        BRESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        RDATA: begin
          if (rready) begin
            rvalid <= 1'b0;
            if (rlast) begin
              state <= IDLE;
            end else begin
              addr_q <= addr_nxt;
              cnt_q  <= cnt_q + 8'd1;
              psel   <= 1'b1;
              paddr  <= addr_nxt;
              state  <= SETUP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_apb_bridge.sv
// Scoreboard bench for axi_apb_bridge: AXI tasks push expected APB/R/B items at address
// handshake, a forked monitor pops and compares them as the DUT produces them.
module tb_axi_apb_bridge;
  localparam int IW = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DB = 4;

  logic          pclk = 1'b0;
  logic          aresetn;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr, paddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot, pprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, awlock, arvalid, arready, arlock;
  logic [3:0]    awcache, arcache;
  logic [DW-1:0] wdata, rdata, pwdata, prdata;
  logic [DB-1:0] wstrb, pstrb;
  logic          wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic          psel, penable, pwrite, pready, pslverr;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
    logic [DB-1:0] strb;
    logic [2:0]    prot;
  } apb_t;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_t;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_t;

  apb_t exp_apb[$];
  r_t   exp_r[$];
  b_t   exp_b[$];

  int            n_checks = 0;
  int            n_pass = 0;
  int            pdelay = 0;
  int            acc_cnt = 0;
  logic          err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;

  always #5 pclk = ~pclk;

  // APB completer: wait states set by pdelay, error on one chosen address, address-tagged read data.
  assign pready  = psel && penable && (acc_cnt >= pdelay);
  assign pslverr = psel && penable && err_en && (paddr == err_addr);
  assign prdata  = {16'hBEEF, 6'd0, paddr};
  always @(posedge pclk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;

  axi_apb_bridge #(.IWIDTH(IW), .AWIDTH(AW), .DSIZE(2)) dut (
    .pclk(pclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awprot(awprot), .awvalid(awvalid), .awlock(awlock), .awcache(awcache), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arprot(arprot), .arvalid(arvalid), .arlock(arlock), .arcache(arcache), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot), .paddr(paddr),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  function automatic logic [AW-1:0] beat_addr(input int start, input int size, input int burst,
                                              input int len, input int i);
    int step, bound, base;
    step = 1 << size;
    if (burst == 0) return AW'(start);
    if (burst == 2) begin
      bound = (len + 1) * step;
      base  = (start / bound) * bound;
      return AW'(base + ((start - base + i * step) % bound));
    end
    return AW'(start + i * step);
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [DW-1:0] first, input int i);
    return first + DW'(i) * 32'h0101_0101;
  endfunction

  function automatic logic [DB-1:0] beat_strb(input int i);
    return 4'hF >> (i % 4);
  endfunction

  task automatic monitor();
    apb_t e;
    r_t   er;
    b_t   eb;
    logic saw_setup;
    saw_setup = 1'b0;
    forever begin
      @(negedge pclk);
      if (!aresetn) begin
        saw_setup = 1'b0;
        continue;
      end
      if (psel && !penable) saw_setup = 1'b1;
      if (psel && penable && pready) begin
        n_checks++;
        if (exp_apb.size() == 0) begin
          $display("FAIL apb_unexpected got addr=%h wr=%b, want no transfer", paddr, pwrite);
        end else begin
          e = exp_apb.pop_front();
          if (paddr !== e.addr || pwrite !== e.wr || pstrb !== e.strb || pprot !== e.prot ||
              (e.wr && pwdata !== e.data) || !saw_setup)
            $display("FAIL apb_beat got addr=%h wr=%b data=%h strb=%h prot=%h setup=%b want addr=%h wr=%b data=%h strb=%h prot=%h setup=1",
                     paddr, pwrite, pwdata, pstrb, pprot, saw_setup, e.addr, e.wr, e.data, e.strb, e.prot);
          else n_pass++;
        end
        saw_setup = 1'b0;
      end
      if (rvalid && rready) begin
        n_checks++;
        if (exp_r.size() == 0) begin
          $display("FAIL r_unexpected got rid=%h rdata=%h, want no beat", rid, rdata);
        end else begin
          er = exp_r.pop_front();
          if (rid !== er.id || rdata !== er.data || rresp !== er.resp || rlast !== er.last)
            $display("FAIL r_beat got id=%h data=%h resp=%b last=%b want id=%h data=%h resp=%b last=%b",
                     rid, rdata, rresp, rlast, er.id, er.data, er.resp, er.last);
          else n_pass++;
        end
      end
      if (bvalid && bready) begin
        n_checks++;
        if (exp_b.size() == 0) begin
          $display("FAIL b_unexpected got bid=%h bresp=%b, want no response", bid, bresp);
        end else begin
          eb = exp_b.pop_front();
          if (bid !== eb.id || bresp !== eb.resp)
            $display("FAIL b_resp got id=%h resp=%b want id=%h resp=%b", bid, bresp, eb.id, eb.resp);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input int size, input int burst, input logic [2:0] prot,
                           input logic [DW-1:0] first);
    int      t;
    apb_t    e;
    b_t      eb;
    logic [AW-1:0] a;
    eb.id = id;
    eb.resp = 2'b00;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awprot = prot; awvalid = 1'b1;
    t = 0;
    @(negedge pclk);
    while (!awready && t < 600) begin @(negedge pclk); t++; end
    if (!awready) begin
      n_checks++;
      $display("FAIL aw_handshake id=%h got awready=%b want 1", id, awready);
      awvalid = 1'b0;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, burst, len, i);
      e.addr = a; e.wr = 1'b1; e.data = beat_data(first, i); e.strb = beat_strb(i); e.prot = prot;
      exp_apb.push_back(e);
      if (err_en && a == err_addr) eb.resp = 2'b10;
    end
    exp_b.push_back(eb);
    @(posedge pclk); #1 awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = beat_data(first, i); wstrb = beat_strb(i); wlast = (i == len); wvalid = 1'b1;
      t = 0;
      @(negedge pclk);
      while (!wready && t < 600) begin @(negedge pclk); t++; end
      if (!wready) begin
        n_checks++;
        $display("FAIL w_handshake beat=%0d got wready=%b want 1", i, wready);
        wvalid = 1'b0;
        return;
      end
      @(posedge pclk); #1 wvalid = 1'b0;
    end
    t = 0;
    while (exp_b.size() != 0 && t < 2000) begin @(negedge pclk); t++; end
    if (exp_b.size() != 0) begin
      n_checks++;
      $display("FAIL b_timeout id=%h got bvalid=%b want a response", id, bvalid);
    end
  endtask

  task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                          input int size, input int burst, input logic [2:0] prot);
    int      t;
    apb_t    e;
    r_t      er;
    logic [AW-1:0] a;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arprot = prot; arvalid = 1'b1;
    t = 0;
    @(negedge pclk);
    while (!arready && t < 600) begin @(negedge pclk); t++; end
    if (!arready) begin
      n_checks++;
      $display("FAIL ar_handshake id=%h got arready=%b want 1", id, arready);
      arvalid = 1'b0;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, size, burst, len, i);
      e.addr = a; e.wr = 1'b0; e.data = '0; e.strb = '0; e.prot = prot;
      exp_apb.push_back(e);
      er.id = id; er.data = {16'hBEEF, 6'd0, a};
      er.resp = (err_en && a == err_addr) ? 2'b10 : 2'b00;
      er.last = (i == len);
      exp_r.push_back(er);
    end
    @(posedge pclk); #1 arvalid = 1'b0;
    t = 0;
    while (exp_r.size() != 0 && t < 3000) begin @(negedge pclk); t++; end
    if (exp_r.size() != 0) begin
      n_checks++;
      $display("FAIL r_timeout id=%h got %0d beats outstanding want 0", id, exp_r.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    n_checks++;
    if (awready !== 1'b0 || arready !== 1'b0)
      $display("FAIL reset_ready_gate got awready=%b arready=%b want 0 0", awready, arready);
    else n_pass++;
    awvalid = 1'b0; arvalid = 1'b0;
    n_checks++;
    if ({psel, penable, pwrite, bvalid, rvalid, wready} !== 6'b0)
      $display("FAIL reset_ctrl got psel=%b penable=%b pwrite=%b bvalid=%b rvalid=%b wready=%b want all 0",
               psel, penable, pwrite, bvalid, rvalid, wready);
    else n_pass++;
    n_checks++;
    if (paddr !== '0 || pstrb !== '0 || pwdata !== '0 || pprot !== '0)
      $display("FAIL reset_data got paddr=%h pstrb=%h pwdata=%h pprot=%h want 0", paddr, pstrb, pwdata, pprot);
    else n_pass++;
    @(posedge pclk); #1 aresetn = 1'b1;
    @(posedge pclk); #1;
    n_checks++;
    if (psel !== 1'b0 || awready !== 1'b0)
      $display("FAIL idle_after_reset got psel=%b awready=%b want 0 0", psel, awready);
    else n_pass++;
  endtask

  task automatic test_single_write();
    axi_write(4'h3, 10'h010, 0, 2, 1, 3'b010, 32'hA5A5_A5A5);
  endtask

  task automatic test_incr_read();
    pdelay = 2;
    axi_read(4'h5, 10'h020, 3, 2, 1, 3'b001);
    pdelay = 0;
  endtask

  task automatic test_wrap_write();
    err_en = 1'b1; err_addr = 10'h03C;
    axi_write(4'h9, 10'h038, 3, 2, 2, 3'b000, 32'h1000_0001);
    err_en = 1'b0;
  endtask

  task automatic test_backpressure();
    err_en = 1'b1; err_addr = 10'h108;
    rready = 1'b0;
    fork
      axi_read(4'h2, 10'h100, 3, 2, 1, 3'b000);
      begin
        int t;
        logic [DW-1:0] d;
        t = 0;
        @(negedge pclk);
        while (!rvalid && t < 200) begin @(negedge pclk); t++; end
        if (!rvalid) begin
          n_checks++;
          $display("FAIL bp_rvalid got rvalid=%b want 1", rvalid);
        end else begin
          d = rdata;
          for (int k = 0; k < 5; k++) begin
            @(negedge pclk);
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== d || psel !== 1'b0)
              $display("FAIL bp_hold cycle=%0d got rvalid=%b rdata=%h psel=%b want 1 %h 0", k, rvalid, rdata, psel, d);
            else n_pass++;
          end
        end
        @(posedge pclk); #1 rready = 1'b1;
      end
    join
    err_en = 1'b0;
  endtask

  task automatic test_addr_modes();
    axi_read(4'h1, 10'h040, 1, 2, 0, 3'b000);
    axi_write(4'h4, 10'h3FC, 1, 2, 1, 3'b100, 32'h5555_0000);
    axi_read(4'h6, 10'h080, 1, 2, 3, 3'b000);
    axi_read(4'h8, 10'h002, 3, 0, 2, 3'b000);
  endtask

  task automatic test_arbitration();
    @(posedge pclk); #1 aresetn = 1'b0;
    @(posedge pclk); #1 aresetn = 1'b1;
    fork
      axi_write(4'hA, 10'h050, 0, 2, 1, 3'b000, 32'hAAAA_0000);
      axi_read(4'hB, 10'h060, 0, 2, 1, 3'b000);
      begin
        @(negedge pclk);
        n_checks++;
        if (awready !== 1'b1 || arready !== 1'b0)
          $display("FAIL arb_first got awready=%b arready=%b want 1 0", awready, arready);
        else n_pass++;
      end
    join
    @(posedge pclk); #1;
    fork
      axi_write(4'hC, 10'h070, 0, 2, 1, 3'b000, 32'hCCCC_0000);
      axi_read(4'hD, 10'h074, 0, 2, 1, 3'b000);
      begin
        @(negedge pclk);
        n_checks++;
        if (awready !== 1'b1 || arready !== 1'b0)
          $display("FAIL arb_after_read got awready=%b arready=%b want 1 0", awready, arready);
        else n_pass++;
      end
    join
    axi_write(4'hE, 10'h078, 0, 2, 1, 3'b000, 32'hEEEE_0000);
    @(posedge pclk); #1;
    fork
      axi_write(4'hF, 10'h07C, 0, 2, 1, 3'b000, 32'hFFFF_0000);
      axi_read(4'h0, 10'h080, 0, 2, 1, 3'b000);
      begin
        @(negedge pclk);
        n_checks++;
        if (awready !== 1'b0 || arready !== 1'b1)
          $display("FAIL arb_after_write got awready=%b arready=%b want 0 1", awready, arready);
        else n_pass++;
      end
    join
  endtask

  task automatic test_reset_midburst();
    int   t;
    apb_t e;
    r_t   er;
    pdelay = 3;
    e.addr = 10'h200; e.wr = 1'b0; e.data = '0; e.strb = '0; e.prot = 3'b000;
    exp_apb.push_back(e);
    er.id = 4'h6; er.data = {16'hBEEF, 6'd0, 10'h200}; er.resp = 2'b00; er.last = 1'b0;
    exp_r.push_back(er);
    @(posedge pclk); #1;
    arid = 4'h6; araddr = 10'h200; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
    arprot = 3'b000; arvalid = 1'b1;
    t = 0;
    @(negedge pclk);
    while (!arready && t < 100) begin @(negedge pclk); t++; end
    @(posedge pclk); #1 arvalid = 1'b0;
    t = 0;
    @(negedge pclk);
    while (!(psel && penable && paddr == 10'h204) && t < 300) begin @(negedge pclk); t++; end
    if (!(psel && penable)) begin
      n_checks++;
      $display("FAIL rst_reach_beat2 got psel=%b penable=%b paddr=%h want 1 1 204", psel, penable, paddr);
    end
    #1 aresetn = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, rvalid, bvalid} !== 4'b0)
      $display("FAIL rst_async got psel=%b penable=%b rvalid=%b bvalid=%b want all 0", psel, penable, rvalid, bvalid);
    else n_pass++;
    awvalid = 1'b1; arvalid = 1'b1;
    #1;
    n_checks++;
    if (awready !== 1'b0 || arready !== 1'b0)
      $display("FAIL rst_ready_gate got awready=%b arready=%b want 0 0", awready, arready);
    else n_pass++;
    awvalid = 1'b0; arvalid = 1'b0;
    @(posedge pclk); #1 aresetn = 1'b1;
    n_checks++;
    if (exp_apb.size() != 0 || exp_r.size() != 0)
      $display("FAIL rst_beat1 got apb_left=%0d r_left=%0d want 0 0", exp_apb.size(), exp_r.size());
    else n_pass++;
    pdelay = 0;
    repeat (3) @(posedge pclk);
    #1;
    axi_write(4'h7, 10'h00C, 1, 2, 1, 3'b011, 32'h7777_0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awprot = '0;
    awvalid = 1'b0; awlock = 1'b0; awcache = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arprot = '0;
    arvalid = 1'b0; arlock = 1'b0; arcache = '0; rready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_single_write();
    test_incr_read();
    test_wrap_write();
    test_backpressure();
    test_addr_modes();
    test_arbitration();
    test_reset_midburst();
    repeat (5) @(posedge pclk);
    #1;
    n_checks++;
    if (exp_apb.size() != 0 || exp_r.size() != 0 || exp_b.size() != 0)
      $display("FAIL drain got apb=%0d r=%0d b=%0d outstanding want 0 0 0",
               exp_apb.size(), exp_r.size(), exp_b.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
